// File: rtl/bw_clk_cclk_div_nx.sv
// Multi-channel programmable clock divider with glitch-free divide/polarity reload.
// Define BW_CLK_DIV_SYNC_PLS_EN to add the per-channel sync_pls output.
module bw_clk_cclk_div_nx #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 4
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    div_ld,
    input  logic [NCH*DW-1:0] div_val,
    input  logic [NCH-1:0]    inv_sel,
    output logic [NCH-1:0]    clkout,
    output logic [NCH-1:0]    ld_ack
`ifdef BW_CLK_DIV_SYNC_PLS_EN
    ,
    output logic [NCH-1:0]    sync_pls
`endif
);

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        RUN_HI = 2'd1,
        RUN_LO = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Reset asserts asynchronously through the synchronizer flops, releases on rclk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t        st_q, st_d;
        logic [DW-1:0] cnt_q, cnt_d;
        logic [DW-1:0] dact_q, dact_d;
        logic [DW-1:0] dpend_q, dpend_d;
        logic          inv_q, inv_d;
        logic          invp_q, invp_d;
        logic          pend_q, pend_d;
        logic          clk_q, clk_d;
        logic          ack_q, ack_d;
        logic          act;
        logic          tc;
`ifdef BW_CLK_DIV_SYNC_PLS_EN
        logic          sync_q, sync_d;
`endif

        assign tc = (cnt_q == dact_q);

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            act   = 1'b0;
            case (st_q)
                PARK: begin
                    act = pend_q;
                    if (en[g]) begin
                        st_d  = RUN_HI;
                        cnt_d = '0;
                    end
                end
                // STOP is a high phase that parks at its end unless en returns.
                RUN_HI, STOP: begin
                    if (tc) begin
                        st_d  = en[g] ? RUN_LO : PARK;
                        cnt_d = '0;
                    end else begin
                        st_d  = en[g] ? RUN_HI : STOP;
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                RUN_LO: begin
                    if (!en[g]) begin
                        st_d  = PARK;
                        cnt_d = '0;
                    end else if (tc) begin
                        st_d  = RUN_HI;
                        cnt_d = '0;
                        act   = pend_q;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                default: begin
                    st_d  = PARK;
                    cnt_d = '0;
                end
            endcase

            dact_d  = act ? dpend_q : dact_q;
            inv_d   = act ? invp_q  : inv_q;
            // A new load on the activation cycle stays pending behind the one activating.
            pend_d  = div_ld[g] ? 1'b1 : (act ? 1'b0 : pend_q);
            dpend_d = div_ld[g] ? div_val[g*DW +: DW] : dpend_q;
            invp_d  = div_ld[g] ? inv_sel[g] : invp_q;
            ack_d   = act;
            clk_d   = ((st_d == RUN_HI) || (st_d == STOP)) ^ inv_d;
`ifdef BW_CLK_DIV_SYNC_PLS_EN
            sync_d  = (st_d == RUN_HI) && ((st_q == PARK) || (st_q == RUN_LO));
`endif
        end

        always_ff @(posedge rclk or negedge rst_n) begin
            if (!rst_n) begin
                st_q    <= PARK;
                cnt_q   <= '0;
                dact_q  <= '0;
                dpend_q <= '0;
                inv_q   <= 1'b0;
                invp_q  <= 1'b0;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                ack_q   <= 1'b0;
`ifdef BW_CLK_DIV_SYNC_PLS_EN
                sync_q  <= 1'b0;
`endif
            end else begin
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                dact_q  <= dact_d;
                dpend_q <= dpend_d;
                inv_q   <= inv_d;
                invp_q  <= invp_d;
                pend_q  <= pend_d;
                clk_q   <= clk_d;
                ack_q   <= ack_d;
`ifdef BW_CLK_DIV_SYNC_PLS_EN
                sync_q  <= sync_d;
`endif
            end
        end

        assign clkout[g] = clk_q;
        assign ld_ack[g] = ack_q;
`ifdef BW_CLK_DIV_SYNC_PLS_EN
        assign sync_pls[g] = sync_q;
`endif
    end

endmodule
